// File: rtl/store_drain_ctrl_pkg.sv
// store_drain_ctrl_pkg
//   Shared types for the store drain path: retire/completion packets from the
//   store queue, memory access size, and the drain FSM state encoding.
//   Widths (XLEN, N_WAY, N_SQ) are core-wide configuration.
package store_drain_ctrl_pkg;

    localparam int XLEN     = 32;
    localparam int N_WAY    = 3;
    localparam int N_SQ     = 8;
    localparam int SQ_IDX_W = $clog2(N_SQ);

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     address;
        logic [XLEN-1:0]     data;
        MEM_SIZE             size;
        logic [SQ_IDX_W-1:0] store_pos;
    } STORE_PACKET_RET;

    typedef struct packed {
        logic                valid;
        logic [SQ_IDX_W-1:0] store_pos;
    } STORE_PACKET_EX_STAGE;

    typedef enum logic [1:0] {
        IDLE = 2'h0,
        REQ  = 2'h1,
        WAIT = 2'h2,
        DONE = 2'h3
    } DRAIN_STATE;

endpackage

// File: rtl/store_drain_ctrl_drain_fifo.sv
// drain_fifo
//   In-order circular buffer of retired stores. Accepts up to N_WAY pushes per
//   cycle (valid lanes compacted in lane order) and one pop per cycle.
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   push_pkt      : retiring stores, lane 0 oldest
//   pop           : remove head entry this edge (caller guarantees non-empty)
//   occupancy     : entries currently held (0..DEPTH)
//   empty         : pointers equal
//   head          : oldest entry
//   drop          : at least one valid lane did not fit this cycle
module drain_fifo
    import store_drain_ctrl_pkg::*;
#(
    parameter int DEPTH = N_SQ
) (
    input  logic                              clock,
    input  logic                              reset,
    input  STORE_PACKET_RET [N_WAY-1:0]       push_pkt,
    input  logic                              pop,
    output logic [$clog2(DEPTH):0]            occupancy,
    output logic                              empty,
    output STORE_PACKET_RET                   head,
    output logic                              drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    STORE_PACKET_RET mem [DEPTH];

    // Extra MSB distinguishes full from empty when the low bits match.
    logic [PW-1:0]              wptr, rptr;
    logic [PW-1:0]              space, cnt, n_acc;
    logic [N_WAY-1:0]           acc;
    logic [N_WAY-1:0][AW-1:0]   waddr;

    assign occupancy = wptr - rptr;
    assign empty     = (wptr == rptr);
    assign head      = mem[rptr[AW-1:0]];

    // A pop on the same edge frees a slot for this cycle's pushes.
    // Lanes past the available space are dropped, highest lanes first.
    always_comb begin
        space = PW'(DEPTH) - occupancy + PW'(pop);
        cnt   = '0;
        n_acc = '0;
        drop  = 1'b0;
        acc   = '0;
        waddr = '0;
        for (int i = 0; i < N_WAY; i++) begin
            waddr[i] = AW'(wptr + cnt);
            if (push_pkt[i].valid) begin
                if (cnt < space) begin
                    acc[i] = 1'b1;
                    n_acc  = n_acc + PW'(1);
                end else begin
                    drop = 1'b1;
                end
                cnt = cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + n_acc;
            if (pop) rptr <= rptr + PW'(1);
        end
    end

    // Storage needs no reset; only the pointers define what is live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_WAY; i++)
            if (acc[i] && !reset) mem[waddr[i]] <= push_pkt[i];
    end

endmodule

// File: rtl/store_drain_ctrl.sv
// store_drain_ctrl
//   Drains committed stores, in order, into the single dcache write port and
//   reports each completion back to the store queue.
// Ports:
//   clock, reset    : clock, synchronous active-high reset
//   ret_packet_in   : up to N_WAY retiring stores per cycle, lane 0 oldest
//   drain_free      : free FIFO slots (registered state)
//   dc_wr_*         : write request (valid/addr/data/size), ready, done
//   store_done_out  : one-cycle completion with store_pos
//   drain_busy      : FIFO non-empty or a request in flight
//   overflow_err    : sticky, set when retirements exceeded free slots
module store_drain_ctrl
    import store_drain_ctrl_pkg::*;
#(
    parameter int DEPTH = N_SQ
) (
    input  logic                          clock,
    input  logic                          reset,
    input  STORE_PACKET_RET [N_WAY-1:0]   ret_packet_in,
    output logic [$clog2(DEPTH):0]        drain_free,
    output logic                          dc_wr_valid,
    output logic [XLEN-1:0]               dc_wr_addr,
    output logic [XLEN-1:0]               dc_wr_data,
    output MEM_SIZE                       dc_wr_size,
    input  logic                          dc_wr_ready,
    input  logic                          dc_wr_done,
    output STORE_PACKET_EX_STAGE          store_done_out,
    output logic                          drain_busy,
    output logic                          overflow_err
);

    localparam int PW = $clog2(DEPTH) + 1;

    DRAIN_STATE          state, state_nxt;
    logic [PW-1:0]       occupancy;
    logic                fifo_empty, pop, drop;
    STORE_PACKET_RET     head;
    logic [XLEN-1:0]     req_addr, req_data;
    MEM_SIZE             req_size;
    logic [SQ_IDX_W-1:0] req_pos;

    // Only valid entries are ever stored, so the head's valid bit carries no info.
    logic unused_head_valid;
    assign unused_head_valid = head.valid;

    drain_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_pkt  (ret_packet_in),
        .pop       (pop),
        .occupancy (occupancy),
        .empty     (fifo_empty),
        .head      (head),
        .drop      (drop)
    );

    // Pop coincides with latching the head into the request registers.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
                state_nxt = REQ;
                pop       = 1'b1;
            end
            REQ:  if (dc_wr_ready) state_nxt = dc_wr_done ? DONE : WAIT;
            WAIT: if (dc_wr_done)  state_nxt = DONE;
            DONE: if (!fifo_empty) begin
                state_nxt = REQ;
                pop       = 1'b1;
            end else begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            req_addr     <= '0;
            req_data     <= '0;
            req_size     <= BYTE;
            req_pos      <= '0;
            overflow_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                req_addr <= head.address;
                req_data <= head.data;
                req_size <= head.size;
                req_pos  <= head.store_pos;
            end
            if (drop) overflow_err <= 1'b1;
        end
    end

    assign dc_wr_valid              = (state == REQ);
    assign dc_wr_addr               = req_addr;
    assign dc_wr_data               = req_data;
    assign dc_wr_size               = req_size;
    assign store_done_out.valid     = (state == DONE);
    assign store_done_out.store_pos = (state == DONE) ? req_pos : '0;
    assign drain_free               = PW'(DEPTH) - occupancy;
    assign drain_busy               = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl (N_WAY=3, DEPTH=8).
module tb_store_drain_ctrl;
    import store_drain_ctrl_pkg::*;

    localparam int DEPTH = N_SQ;

    logic                        clock = 1'b0;
    logic                        reset;
    STORE_PACKET_RET [N_WAY-1:0] ret_packet_in;
    logic [$clog2(DEPTH):0]      drain_free;
    logic                        dc_wr_valid;
    logic [XLEN-1:0]             dc_wr_addr, dc_wr_data;
    MEM_SIZE                     dc_wr_size;
    logic                        dc_wr_ready, dc_wr_done;
    STORE_PACKET_EX_STAGE        store_done_out;
    logic                        drain_busy, overflow_err;

    int checks   = 0;
    int failures = 0;

    store_drain_ctrl #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .ret_packet_in  (ret_packet_in),
        .drain_free     (drain_free),
        .dc_wr_valid    (dc_wr_valid),
        .dc_wr_addr     (dc_wr_addr),
        .dc_wr_data     (dc_wr_data),
        .dc_wr_size     (dc_wr_size),
        .dc_wr_ready    (dc_wr_ready),
        .dc_wr_done     (dc_wr_done),
        .store_done_out (store_done_out),
        .drain_busy     (drain_busy),
        .overflow_err   (overflow_err)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lane(input int i, input logic [31:0] a, input logic [31:0] d,
                        input MEM_SIZE s, input logic [2:0] p);
        ret_packet_in[i] = '{valid: 1'b1, address: a, data: d, size: s, store_pos: p};
    endtask

    initial begin
        reset         = 1'b1;
        ret_packet_in = '0;
        dc_wr_ready   = 1'b0;
        dc_wr_done    = 1'b0;
        tick; tick;

        // Reset state
        chk("rst_valid", 64'(dc_wr_valid), 64'd0);
        chk("rst_addr",  64'(dc_wr_addr), 64'd0);
        chk("rst_data",  64'(dc_wr_data), 64'd0);
        chk("rst_size",  64'(dc_wr_size), 64'd0);
        chk("rst_done",  64'(store_done_out), 64'd0);
        chk("rst_free",  64'(drain_free), 64'(DEPTH));
        chk("rst_busy",  64'(drain_busy), 64'd0);
        chk("rst_ovf",   64'(overflow_err), 64'd0);
        reset = 1'b0;

        // Three lanes, ready/done immediate: writes on t+2, t+4, t+6
        dc_wr_ready = 1'b1;
        dc_wr_done  = 1'b1;
        lane(0, 32'h100, 32'h11, WORD, 3'd1);
        lane(1, 32'h104, 32'h22, WORD, 3'd2);
        lane(2, 32'h108, 32'h33, WORD, 3'd3);
        tick; ret_packet_in = '0;                      // t+1
        chk("t1_free",  64'(drain_free), 64'd5);
        chk("t1_valid", 64'(dc_wr_valid), 64'd0);
        chk("t1_busy",  64'(drain_busy), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick;                                      // REQ
            chk("t1_req_valid", 64'(dc_wr_valid), 64'd1);
            chk("t1_req_addr",  64'(dc_wr_addr), 64'h100 + 64'(4 * k));
            chk("t1_req_data",  64'(dc_wr_data), 64'h11 * 64'(k + 1));
            chk("t1_req_free",  64'(drain_free), 64'(6 + k));
            tick;                                      // DONE
            chk("t1_done_v",   64'(store_done_out.valid), 64'd1);
            chk("t1_done_pos", 64'(store_done_out.store_pos), 64'(k + 1));
            chk("t1_done_nv",  64'(dc_wr_valid), 64'd0);
        end
        tick;
        chk("t1_end_busy", 64'(drain_busy), 64'd0);
        chk("t1_end_free", 64'(drain_free), 64'(DEPTH));
        chk("t1_end_done", 64'(store_done_out.valid), 64'd0);

        // Single store, ready low 5 cycles, then ready without done -> WAIT
        dc_wr_ready = 1'b0;
        dc_wr_done  = 1'b0;
        lane(0, 32'h200, 32'hAA, HALF, 3'd4);
        tick; ret_packet_in = '0;
        tick;                                          // REQ
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_valid", 64'(dc_wr_valid), 64'd1);
            chk("t2_hold_addr",  64'(dc_wr_addr), 64'h200);
            chk("t2_hold_data",  64'(dc_wr_data), 64'hAA);
            chk("t2_hold_size",  64'(dc_wr_size), 64'(HALF));
            tick;
        end
        chk("t2_hold_valid_last", 64'(dc_wr_valid), 64'd1);
        dc_wr_ready = 1'b1;
        tick;                                          // WAIT
        dc_wr_ready = 1'b0;
        chk("t2_wait_valid", 64'(dc_wr_valid), 64'd0);
        chk("t2_wait_busy",  64'(drain_busy), 64'd1);
        tick;
        chk("t2_wait_nodone1", 64'(store_done_out.valid), 64'd0);
        tick;
        chk("t2_wait_nodone2", 64'(store_done_out.valid), 64'd0);
        dc_wr_done = 1'b1;
        tick;                                          // DONE
        dc_wr_done = 1'b0;
        chk("t2_done_v",   64'(store_done_out.valid), 64'd1);
        chk("t2_done_pos", 64'(store_done_out.store_pos), 64'd4);
        tick;
        chk("t2_done_once", 64'(store_done_out.valid), 64'd0);
        chk("t2_idle_busy", 64'(drain_busy), 64'd0);

        // Lanes {valid, invalid, valid} compact to two contiguous entries
        dc_wr_ready = 1'b1;
        dc_wr_done  = 1'b1;
        lane(0, 32'h300, 32'h55, BYTE, 3'd5);
        lane(2, 32'h308, 32'h66, BYTE, 3'd6);
        tick; ret_packet_in = '0;
        chk("t3_free", 64'(drain_free), 64'd6);
        tick;
        chk("t3_addr0", 64'(dc_wr_addr), 64'h300);
        tick;
        chk("t3_pos0", 64'(store_done_out.store_pos), 64'd5);
        tick;
        chk("t3_addr1", 64'(dc_wr_addr), 64'h308);
        chk("t3_data1", 64'(dc_wr_data), 64'h66);
        tick;
        chk("t3_pos1", 64'(store_done_out.store_pos), 64'd6);
        tick;
        chk("t3_end_free", 64'(drain_free), 64'(DEPTH));

        // Fill to DEPTH (one entry also sits in the request regs), then overflow
        dc_wr_ready = 1'b0;
        dc_wr_done  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 3; i++)
                lane(i, 32'h400 + 32'(4 * (3 * c + i)), 32'(3 * c + i), WORD, 3'(3 * c + i));
            tick;
        end
        chk("t4_full_free", 64'(drain_free), 64'd0);
        chk("t4_full_ovf",  64'(overflow_err), 64'd0);
        ret_packet_in = '0;
        lane(0, 32'h424, 32'h99, WORD, 3'd7);
        tick; ret_packet_in = '0;
        chk("t4_ovf_set",  64'(overflow_err), 64'd1);
        chk("t4_ovf_free", 64'(drain_free), 64'd0);
        tick;
        chk("t4_ovf_sticky", 64'(overflow_err), 64'd1);
        dc_wr_ready = 1'b1;
        dc_wr_done  = 1'b1;
        chk("t4_drain_addr0", 64'(dc_wr_addr), 64'h400);
        for (int k = 1; k < 9; k++) begin
            tick; tick;
            chk("t4_drain_addr", 64'(dc_wr_addr), 64'h400 + 64'(4 * k));
        end
        tick; tick;
        chk("t4_end_busy",  64'(drain_busy), 64'd0);
        chk("t4_end_valid", 64'(dc_wr_valid), 64'd0);
        chk("t4_end_free",  64'(drain_free), 64'(DEPTH));

        // Push 2 alongside a pop at DEPTH-1 occupancy; pointers wrap
        dc_wr_ready = 1'b0;
        dc_wr_done  = 1'b0;
        for (int i = 0; i < 3; i++) lane(i, 32'h500 + 32'(4 * i), 32'(i), WORD, 3'(i));
        tick;
        for (int i = 0; i < 3; i++) lane(i, 32'h50C + 32'(4 * i), 32'(3 + i), WORD, 3'(3 + i));
        tick; ret_packet_in = '0;
        lane(0, 32'h518, 32'd6, WORD, 3'd6);
        lane(1, 32'h51C, 32'd7, WORD, 3'd7);
        tick; ret_packet_in = '0;
        chk("t5_occ7_free", 64'(drain_free), 64'd1);
        dc_wr_ready = 1'b1;
        dc_wr_done  = 1'b1;
        tick;                                          // DONE, pop next edge
        dc_wr_ready = 1'b0;
        dc_wr_done  = 1'b0;
        lane(0, 32'h520, 32'd8, WORD, 3'd0);
        lane(1, 32'h524, 32'd9, WORD, 3'd1);
        tick; ret_packet_in = '0;
        chk("t5_full_free", 64'(drain_free), 64'd0);
        chk("t5_req_addr",  64'(dc_wr_addr), 64'h504);
        dc_wr_ready = 1'b1;
        dc_wr_done  = 1'b1;
        for (int k = 2; k < 10; k++) begin
            tick; tick;
            chk("t5_drain_addr", 64'(dc_wr_addr), 64'h500 + 64'(4 * k));
        end
        tick; tick;
        chk("t5_end_free", 64'(drain_free), 64'(DEPTH));
        chk("t5_end_busy", 64'(drain_busy), 64'd0);

        // Reset while in WAIT with two entries queued
        dc_wr_ready = 1'b0;
        dc_wr_done  = 1'b0;
        for (int i = 0; i < 3; i++) lane(i, 32'h600 + 32'(4 * i), 32'(i), WORD, 3'(i));
        tick; ret_packet_in = '0;
        tick;                                          // REQ, 2 queued
        dc_wr_ready = 1'b1;
        tick;                                          // WAIT
        dc_wr_ready = 1'b0;
        chk("t6_wait_valid", 64'(dc_wr_valid), 64'd0);
        chk("t6_wait_free",  64'(drain_free), 64'd6);
        reset = 1'b1;
        tick;
        chk("t6_rst_valid", 64'(dc_wr_valid), 64'd0);
        chk("t6_rst_busy",  64'(drain_busy), 64'd0);
        chk("t6_rst_free",  64'(drain_free), 64'(DEPTH));
        chk("t6_rst_done",  64'(store_done_out.valid), 64'd0);
        chk("t6_rst_ovf",   64'(overflow_err), 64'd0);
        reset      = 1'b0;
        dc_wr_done = 1'b1;                             // stray done in IDLE is ignored
        tick;
        dc_wr_done = 1'b0;
        chk("t6_post_done", 64'(store_done_out.valid), 64'd0);
        chk("t6_post_busy", 64'(drain_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
